// File: rtl/normaliza_resultado.sv
// normaliza_resultado: post-ALU normalise-and-pack stage of the FP adder/subtractor.
// Defining ARREDONDA_EN builds the round-half-to-even ROUND state; otherwise the guard bit is truncated.
module normaliza_resultado #(
    parameter int EXP_W  = 5,
    parameter int MANT_W = 11
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    sinal_in,
    input  logic [EXP_W-1:0]        expoente_in,
    input  logic [MANT_W:0]         mantissa_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+MANT_W-1:0] resultado,
    output logic                    flag_zero,
    output logic                    flag_overflow,
    output logic                    flag_underflow
);

    localparam int               FRAC_W  = MANT_W - 1;
    localparam logic [EXP_W:0]   EMAX    = {1'b0, {EXP_W{1'b1}}};
    localparam logic [EXP_W:0]   EXP_ONE = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [EXP_W-1:0] EMAX_F  = {EXP_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SHIFT_L,
`ifdef ARREDONDA_EN
        ROUND,
`endif
        PACK,
        DONE
    } state_t;

    state_t                    state_q;
    logic                      sign_q;
    logic [EXP_W:0]            exp_q;
    logic [MANT_W:0]           mant_q;
    logic [EXP_W+MANT_W-1:0]   res_q;
    logic                      pend_zero_q;
    logic                      pend_ovf_q;
    logic                      pend_unf_q;
    logic [EXP_W+MANT_W-1:0]   resultado_q;
    logic                      zero_q;
    logic                      ovf_q;
    logic                      unf_q;
    logic                      out_valid_q;
`ifdef ARREDONDA_EN
    logic                      guard_q;
    logic [FRAC_W-1:0]         frac_rnd;
    logic                      rnd_carry;
`endif

    logic [EXP_W:0]            exp_inc;
    logic [EXP_W:0]            exp_dec;
    logic [MANT_W:0]           mant_shr;
    logic [MANT_W:0]           mant_shl;

    function automatic logic [EXP_W+MANT_W-1:0] pack(input logic s,
                                                     input logic [EXP_W-1:0] e,
                                                     input logic [FRAC_W-1:0] f);
        return {s, e, f};
    endfunction

    // Exponent is kept one bit wider so EMAX and 1 can be detected without wrap.
    always_comb begin
        exp_inc  = exp_q + EXP_ONE;
        exp_dec  = exp_q - EXP_ONE;
        mant_shr = mant_q >> 1;
        mant_shl = mant_q << 1;
`ifdef ARREDONDA_EN
        frac_rnd  = mant_q[FRAC_W-1:0] + {{(FRAC_W-1){1'b0}}, 1'b1};
        rnd_carry = &mant_q[FRAC_W:0];
`endif
    end

    // Intermediate result lands in res_q/pend_*; PACK moves it to the output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            res_q       <= '0;
            pend_zero_q <= 1'b0;
            pend_ovf_q  <= 1'b0;
            pend_unf_q  <= 1'b0;
            resultado_q <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef ARREDONDA_EN
            guard_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sign_q      <= sinal_in;
                        exp_q       <= (expoente_in == '0) ? EXP_ONE : {1'b0, expoente_in};
                        mant_q      <= mantissa_in;
                        pend_zero_q <= 1'b0;
                        pend_ovf_q  <= 1'b0;
                        pend_unf_q  <= 1'b0;
                        zero_q      <= 1'b0;
                        ovf_q       <= 1'b0;
                        unf_q       <= 1'b0;
`ifdef ARREDONDA_EN
                        guard_q     <= 1'b0;
`endif
                        state_q     <= CHECK;
                    end
                end
                CHECK: begin
                    if (exp_q == EMAX) begin
                        res_q      <= pack(sign_q, EMAX_F, {FRAC_W{1'b0}});
                        pend_ovf_q <= 1'b1;
                        state_q    <= PACK;
                    end else if (mant_q == '0) begin
                        res_q       <= '0;
                        pend_zero_q <= 1'b1;
                        state_q     <= PACK;
                    end else if (mant_q[MANT_W]) begin
                        mant_q <= mant_shr;
                        exp_q  <= exp_inc;
                        if (exp_inc == EMAX) begin
                            res_q      <= pack(sign_q, EMAX_F, {FRAC_W{1'b0}});
                            pend_ovf_q <= 1'b1;
                            state_q    <= PACK;
                        end else begin
`ifdef ARREDONDA_EN
                            guard_q <= mant_q[0];
                            state_q <= ROUND;
`else
                            res_q   <= pack(sign_q, exp_inc[EXP_W-1:0], mant_shr[FRAC_W-1:0]);
                            state_q <= PACK;
`endif
                        end
                    end else if (mant_q[MANT_W-1]) begin
                        res_q   <= pack(sign_q, exp_q[EXP_W-1:0], mant_q[FRAC_W-1:0]);
                        state_q <= PACK;
                    end else if (exp_q == EXP_ONE) begin
                        res_q      <= pack(sign_q, {EXP_W{1'b0}}, mant_q[FRAC_W-1:0]);
                        pend_unf_q <= 1'b1;
                        state_q    <= PACK;
                    end else begin
                        state_q <= SHIFT_L;
                    end
                end
                SHIFT_L: begin
                    mant_q <= mant_shl;
                    exp_q  <= exp_dec;
                    if (mant_shl[MANT_W-1]) begin
                        res_q   <= pack(sign_q, exp_dec[EXP_W-1:0], mant_shl[FRAC_W-1:0]);
                        state_q <= PACK;
                    end else if (exp_dec == EXP_ONE) begin
                        res_q      <= pack(sign_q, {EXP_W{1'b0}}, mant_shl[FRAC_W-1:0]);
                        pend_unf_q <= 1'b1;
                        state_q    <= PACK;
                    end
                end
`ifdef ARREDONDA_EN
                // A tie rounds up only when the kept LSB is odd; a full carry renormalises.
                ROUND: begin
                    if (guard_q && mant_q[0]) begin
                        if (rnd_carry) begin
                            if (exp_inc == EMAX) begin
                                res_q      <= pack(sign_q, EMAX_F, {FRAC_W{1'b0}});
                                pend_ovf_q <= 1'b1;
                            end else begin
                                res_q <= pack(sign_q, exp_inc[EXP_W-1:0], {FRAC_W{1'b0}});
                            end
                        end else begin
                            res_q <= pack(sign_q, exp_q[EXP_W-1:0], frac_rnd);
                        end
                    end else begin
                        res_q <= pack(sign_q, exp_q[EXP_W-1:0], mant_q[FRAC_W-1:0]);
                    end
                    state_q <= PACK;
                end
`endif
                PACK: begin
                    resultado_q <= res_q;
                    zero_q      <= pend_zero_q;
                    ovf_q       <= pend_ovf_q;
                    unf_q       <= pend_unf_q;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready       = (state_q == IDLE);
    assign out_valid      = out_valid_q;
    assign resultado      = resultado_q;
    assign flag_zero      = zero_q;
    assign flag_overflow  = ovf_q;
    assign flag_underflow = unf_q;

endmodule
